regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 8 x 16-bit register file's single write port (RegWr, addr3, in). Three requesters share that port: ALU result (req 0), memory load data (req 1) and PC-link write (req 2). Each requester pushes into its own small FIFO, and a round-robin arbiter drains one entry per cycle into a registered write stage. A per-register busy vector lets the multi-cycle control unit stall reads of registers that have writes in flight.

---
 rtl/regfile_wb_arbiter_if.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - bus bundle for the register file write-back arbiter
// Purpose: groups the three requester handshakes, flush and the register file
//          write port so the arbiter and its users share one typed connection.
// Signals:
//   flush                                  discard all queued requests
//   alu_/mem_/lnk_ valid, ready, addr, data requester handshakes (addr 3b, data 16b)
//   RegWr, addr3, wb_data                  registered register file write port
//   busy[7:0]                              per-register pending-write flags
//   idle                                   nothing queued and no write in progress
// Modports: master = requesters/register file side, slave = arbiter side.
interface regfile_wb_arbiter_if;
  logic        flush;

  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;

  logic        lnk_valid;
  logic        lnk_ready;
  logic [2:0]  lnk_addr;
  logic [15:0] lnk_data;

  logic        RegWr;
  logic [2:0]  addr3;
  logic [15:0] wb_data;
  logic [7:0]  busy;
  logic        idle;

  modport master (
    output flush,
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output lnk_valid, lnk_addr, lnk_data,
    input  alu_ready, mem_ready, lnk_ready,
    input  RegWr, addr3, wb_data, busy, idle
  );

  modport slave (
    input  flush,
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  lnk_valid, lnk_addr, lnk_data,
    output alu_ready, mem_ready, lnk_ready,
    output RegWr, addr3, wb_data, busy, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the 8 x 16 register file
// Purpose: three requesters (0 = ALU, 1 = memory load, 2 = PC link) each push
//          into a DEPTH-entry FIFO; a round-robin arbiter pops one entry per
//          cycle into a registered write stage that drives the register file.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_arbiter_if.slave (requesters, flush, write port, busy, idle)
// Parameters:
//   DEPTH    entries per requester FIFO (power of 2, >= 2)
//   ZERO_RO  when 1, writes to R0 use an arbitration slot but never raise RegWr
module regfile_wb_arbiter #(
  parameter int DEPTH   = 2,
  parameter bit ZERO_RO = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Requester inputs gathered into indexable form (0 = alu, 1 = mem, 2 = lnk)
  logic [2:0]  in_valid;
  logic [2:0]  in_addr [3];
  logic [15:0] in_data [3];

  assign in_valid   = {bus.lnk_valid, bus.mem_valid, bus.alu_valid};
  assign in_addr[0] = bus.alu_addr;
  assign in_addr[1] = bus.mem_addr;
  assign in_addr[2] = bus.lnk_addr;
  assign in_data[0] = bus.alu_data;
  assign in_data[1] = bus.mem_data;
  assign in_data[2] = bus.lnk_data;

  // FIFO storage and bookkeeping
  logic [2:0]    fifo_addr_q [3][DEPTH];
  logic [2:0]    fifo_addr_d [3][DEPTH];
  logic [15:0]   fifo_data_q [3][DEPTH];
  logic [15:0]   fifo_data_d [3][DEPTH];
  logic [PW-1:0] wr_ptr_q [3];
  logic [PW-1:0] wr_ptr_d [3];
  logic [PW-1:0] rd_ptr_q [3];
  logic [PW-1:0] rd_ptr_d [3];
  logic [CW-1:0] count_q [3];
  logic [CW-1:0] count_d [3];

  // Arbiter pointer and write stage
  logic [1:0]  rr_q, rr_d;
  logic        regwr_q, regwr_d;
  logic [2:0]  addr3_q, addr3_d;
  logic [15:0] wb_data_q, wb_data_d;

  logic [2:0]  full;
  logic [2:0]  nonempty;
  logic [2:0]  push;
  logic [2:0]  pop;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  scan0, scan1, scan2;
  logic [7:0]  busy_v;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int r = 0; r < 3; r++) begin
      full[r]     = (count_q[r] == FULL_CNT);
      nonempty[r] = (count_q[r] != '0);
    end
  end

  // Readiness is purely a function of FIFO occupancy; a pop in the same
  // cycle does not free a slot for a push.
  assign push = in_valid & ~full & {3{~bus.flush}};

  // Round-robin scan order starting at the pointer
  assign scan0 = rr_q;
  assign scan1 = inc3(rr_q);
  assign scan2 = inc3(scan1);

  always_comb begin
    win_valid = 1'b1;
    win_idx   = scan0;
    if (nonempty[scan0]) begin
      win_idx = scan0;
    end else if (nonempty[scan1]) begin
      win_idx = scan1;
    end else if (nonempty[scan2]) begin
      win_idx = scan2;
    end else begin
      win_valid = 1'b0;
    end
  end

  assign pop = win_valid ? (3'b001 << win_idx) : 3'b000;

  // Pointer advances past the winner, holds when nothing is pending or on flush
  assign rr_d = (win_valid && !bus.flush) ? inc3(win_idx) : rr_q;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    for (int r = 0; r < 3; r++) begin
      if (bus.flush) begin
        wr_ptr_d[r] = '0;
        rd_ptr_d[r] = '0;
        count_d[r]  = '0;
      end else begin
        if (push[r]) begin
          fifo_addr_d[r][wr_ptr_q[r]] = in_addr[r];
          fifo_data_d[r][wr_ptr_q[r]] = in_data[r];
          wr_ptr_d[r] = wr_ptr_q[r] + 1'b1;
        end
        if (pop[r]) begin
          rd_ptr_d[r] = rd_ptr_q[r] + 1'b1;
        end
        case ({push[r], pop[r]})
          2'b10:   count_d[r] = count_q[r] + 1'b1;
          2'b01:   count_d[r] = count_q[r] - 1'b1;
          default: count_d[r] = count_q[r];
        endcase
      end
    end
  end

  // Write stage: the winning entry is loaded even during flush so a write
  // already selected completes; R0 entries occupy the slot silently.
  always_comb begin
    regwr_d   = 1'b0;
    addr3_d   = addr3_q;
    wb_data_d = wb_data_q;
    if (win_valid) begin
      addr3_d   = fifo_addr_q[win_idx][rd_ptr_q[win_idx]];
      wb_data_d = fifo_data_q[win_idx][rd_ptr_q[win_idx]];
      regwr_d   = !(ZERO_RO && (addr3_d == 3'd0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        count_q[r]  <= '0;
      end
      rr_q      <= 2'd0;
      regwr_q   <= 1'b0;
      addr3_q   <= 3'd0;
      wb_data_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      regwr_q   <= regwr_d;
      addr3_q   <= addr3_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Entry payloads need no reset: occupancy counters gate every use.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  // Busy: walk only the occupied slots of each FIFO, oldest first
  always_comb begin
    busy_v = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count_q[r]) begin
          busy_v[fifo_addr_q[r][rd_ptr_q[r] + PW'(k)]] = 1'b1;
        end
      end
    end
    if (regwr_q) begin
      busy_v[addr3_q] = 1'b1;
    end
    if (ZERO_RO) begin
      busy_v[0] = 1'b0;
    end
  end

  assign bus.alu_ready = ~full[0];
  assign bus.mem_ready = ~full[1];
  assign bus.lnk_ready = ~full[2];
  assign bus.RegWr     = regwr_q;
  assign bus.addr3     = addr3_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.busy      = busy_v;
  assign bus.idle      = (nonempty == 3'b000) && !regwr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .ZERO_RO(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } entry_t;

  // Reference model: per-requester queues, rotating priority, one write slot
  entry_t      mq [3][$];
  int          m_ptr;
  logic        m_regwr;
  logic [2:0]  m_addr3;
  logic [15:0] m_data;
  logic [15:0] m_rf [8];
  entry_t      exp_q[$];
  entry_t      obs_log[$];

  // Register file fed by the DUT write port
  logic [15:0] rf [8] = '{default: 16'd0};
  always @(posedge clk) if (bus.RegWr) rf[bus.addr3] <= bus.wb_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_v(int i);
    case (i)
      0:       return bus.alu_valid;
      1:       return bus.mem_valid;
      default: return bus.lnk_valid;
    endcase
  endfunction

  function automatic entry_t in_e(int i);
    case (i)
      0:       return {bus.alu_addr, bus.alu_data};
      1:       return {bus.mem_addr, bus.mem_data};
      default: return {bus.lnk_addr, bus.lnk_data};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_ptr   = 0;
    m_regwr = 1'b0;
    m_addr3 = 3'd0;
    m_data  = 16'd0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit     acc [3];
    int     w;
    entry_t e;
    if (m_regwr) m_rf[m_addr3] = m_data;
    for (int i = 0; i < 3; i++)
      acc[i] = in_v(i) && (mq[i].size() < DEPTH) && !bus.flush;
    w = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (w < 0 && mq[i].size() > 0) w = i;
    end
    if (w >= 0) begin
      e       = mq[w].pop_front();
      m_addr3 = e.addr;
      m_data  = e.data;
      m_regwr = (e.addr != 3'd0);
      if (m_regwr) exp_q.push_back(e);
      if (!bus.flush) m_ptr = (w + 1) % 3;
    end else begin
      m_regwr = 1'b0;
    end
    if (bus.flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(in_e(i));
    end
  endtask

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < mq[i].size(); j++) b[mq[i][j].addr] = 1'b1;
    if (m_regwr) b[m_addr3] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic bit model_idle();
    return (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0) && !m_regwr;
  endfunction

  // Model clocking
  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor / scoreboard
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      check("regwr", bus.RegWr, m_regwr);
      if (bus.RegWr === 1'b1) begin
        obs_log.push_back({bus.addr3, bus.wb_data});
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", {bus.addr3, bus.wb_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", bus.addr3, e.addr);
          check("sb_data", bus.wb_data, e.data);
        end
      end
      check("busy", bus.busy, model_busy());
      check("ready", {bus.lnk_ready, bus.mem_ready, bus.alu_ready}, model_ready());
      check("idle", bus.idle, model_idle());
    end
  end

  task automatic drive(int r, bit v, logic [2:0] a, logic [15:0] d);
    case (r)
      0: begin bus.alu_valid = v; bus.alu_addr = a; bus.alu_data = d; end
      1: begin bus.mem_valid = v; bus.mem_addr = a; bus.mem_data = d; end
      default: begin bus.lnk_valid = v; bus.lnk_addr = a; bus.lnk_data = d; end
    endcase
  endtask

  task automatic idle_inputs();
    for (int r = 0; r < 3; r++) drive(r, 1'b0, 3'd0, 16'd0);
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!model_idle() && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 30) check({name, "_drain_timeout"}, n, 0);
  endtask

  initial begin
    bit saw_mem_block;
    idle_inputs();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_regwr", bus.RegWr, 1'b0);
    check("rst_addr3", bus.addr3, 3'd0);
    check("rst_wb_data", bus.wb_data, 16'd0);
    check("rst_busy", bus.busy, 8'h00);
    check("rst_ready", {bus.lnk_ready, bus.mem_ready, bus.alu_ready}, 3'b111);
    check("rst_idle", bus.idle, 1'b1);
    rst_n = 1'b1;

    // 1. Single write, two edges of latency
    @(negedge clk);
    drive(0, 1'b1, 3'd3, 16'h1234);
    @(negedge clk);
    idle_inputs();
    check("t1_busy_after_push", bus.busy[3], 1'b1);
    check("t1_regwr_early", bus.RegWr, 1'b0);
    @(negedge clk);
    check("t1_regwr", bus.RegWr, 1'b1);
    check("t1_addr3", bus.addr3, 3'd3);
    check("t1_wb_data", bus.wb_data, 16'h1234);
    check("t1_busy_during", bus.busy[3], 1'b1);
    @(negedge clk);
    check("t1_regwr_fall", bus.RegWr, 1'b0);
    check("t1_busy_clear", bus.busy[3], 1'b0);
    check("t1_rf_r3", rf[3], 16'h1234);

    // 2. Contention: three pushes at one edge from pointer 0
    do_reset();
    obs_log.delete();
    @(negedge clk);
    drive(0, 1'b1, 3'd1, 16'h1111);
    drive(1, 1'b1, 3'd2, 16'h2222);
    drive(2, 1'b1, 3'd7, 16'h7777);
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    check("t2_count", obs_log.size(), 3);
    if (obs_log.size() >= 3) begin
      check("t2_w0", obs_log[0], {3'd1, 16'h1111});
      check("t2_w1", obs_log[1], {3'd2, 16'h2222});
      check("t2_w2", obs_log[2], {3'd7, 16'h7777});
    end
    check("t2_idle", bus.idle, 1'b1);

    // 3. Backpressure: mem held valid 4 cycles against streaming alu/lnk
    saw_mem_block = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_valid && !bus.mem_ready) saw_mem_block = 1'b1;
      drive(0, 1'b1, 3'(c % 8), 16'hA000 + 16'(c));
      drive(2, 1'b1, 3'((c + 3) % 8), 16'hC000 + 16'(c));
      drive(1, c < 4, 3'((c + 5) % 8), 16'hB000 + 16'(c));
    end
    @(negedge clk);
    if (bus.mem_valid && !bus.mem_ready) saw_mem_block = 1'b1;
    idle_inputs();
    check("t3_mem_backpressure_seen", saw_mem_block, 1'b1);
    drain("t3");

    // 4. R0 protection
    @(negedge clk);
    drive(0, 1'b1, 3'd0, 16'hFFFF);
    @(negedge clk);
    idle_inputs();
    check("t4_busy0_queued", bus.busy[0], 1'b0);
    check("t4_not_idle", bus.idle, 1'b0);
    @(negedge clk);
    check("t4_regwr", bus.RegWr, 1'b0);
    check("t4_busy0", bus.busy[0], 1'b0);
    check("t4_consumed", bus.idle, 1'b1);
    @(negedge clk);
    check("t4_rf_r0", rf[0], 16'h0000);

    // 5. Flush with a concurrent lnk push
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 3'd4, 16'h0A00);
    drive(1, 1'b1, 3'd5, 16'h0B00);
    @(negedge clk);
    drive(0, 1'b1, 3'd4, 16'h0A01);
    drive(1, 1'b1, 3'd5, 16'h0B01);
    @(negedge clk);
    idle_inputs();
    drive(2, 1'b1, 3'd6, 16'h0C00);
    bus.flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("t5_inflight_regwr", bus.RegWr, 1'b1);
    check("t5_inflight_addr", bus.addr3, 3'd5);
    check("t5_inflight_data", bus.wb_data, 16'h0B00);
    check("t5_ready_after_flush", {bus.lnk_ready, bus.mem_ready, bus.alu_ready}, 3'b111);
    @(negedge clk);
    check("t5_regwr_done", bus.RegWr, 1'b0);
    check("t5_busy", bus.busy, 8'h00);
    check("t5_idle", bus.idle, 1'b1);

    // 6. Asynchronous reset mid-stream
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int r = 0; r < 3; r++) drive(r, 1'b1, 3'(r + 1), 16'h6000 + 16'(c * 4 + r));
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_regwr", bus.RegWr, 1'b0);
    check("t6_busy", bus.busy, 8'h00);
    check("t6_ready", {bus.lnk_ready, bus.mem_ready, bus.alu_ready}, 3'b111);
    check("t6_addr3", bus.addr3, 3'd0);
    check("t6_wb_data", bus.wb_data, 16'd0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 3'd2, 16'hBEEF);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("t6_post_regwr", bus.RegWr, 1'b1);
    check("t6_post_addr3", bus.addr3, 3'd2);
    check("t6_post_data", bus.wb_data, 16'hBEEF);

    // Randomized traffic with occasional flush
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int r = 0; r < 3; r++)
        drive(r, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom));
      bus.flush = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    idle_inputs();
    drain("rand");

    check("final_exp_empty", exp_q.size(), 0);
    check("final_idle", bus.idle, 1'b1);
    for (int i = 0; i < 8; i++) check($sformatf("final_rf_r%0d", i), rf[i], m_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
